// File: rtl/rv32_ctrl_pkg.sv
// Shared definitions for the rv32 pipeline control slice: stage indices, event
// encoding and small helpers for stage masks and saturating counters.
package rv32_ctrl_pkg;

  localparam int unsigned MAX_STAGES      = 8;

  localparam int unsigned STAGE_FETCH     = 0;
  localparam int unsigned STAGE_DECODE    = 1;
  localparam int unsigned STAGE_EXECUTE   = 2;
  localparam int unsigned STAGE_MEM       = 3;
  localparam int unsigned STAGE_WRITEBACK = 4;

  typedef enum logic [2:0] {
    EvNone,
    EvMemWait,
    EvBranch,
    EvLoadUse,
    EvFetchWait
  } ctrl_event_e;

  // Bits 0..k set; callers truncate to their own pipeline depth.
  function automatic logic [MAX_STAGES-1:0] prefix_mask(input int unsigned k);
    logic [MAX_STAGES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      if (i <= k) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/rv32_hazard_detect.sv
// Combinational qualification of the four pipeline-control events from the
// stage valid bits and the sideband inputs of the stage modules.
module rv32_hazard_detect
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned REG_BITS = 5
) (
  input  logic                decode_valid_i,
  input  logic                execute_valid_i,
  input  logic                mem_valid_i,
  input  logic                branch_valid_i,
  input  logic                fetch_ready_i,
  input  logic                mem_access_i,
  input  logic                mem_ready_i,
  input  logic                branch_taken_i,
  input  logic [REG_BITS-1:0] rs1_i,
  input  logic [REG_BITS-1:0] rs2_i,
  input  logic                rs1_used_i,
  input  logic                rs2_used_i,
  input  logic [REG_BITS-1:0] execute_rd_i,
  input  logic                execute_mem_read_i,
  output logic                mem_wait_o,
  output logic                branch_o,
  output logic                load_use_o,
  output logic                fetch_wait_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit      = rs1_used_i && (rs1_i == execute_rd_i);
    rs2_hit      = rs2_used_i && (rs2_i == execute_rd_i);
    mem_wait_o   = mem_valid_i && mem_access_i && !mem_ready_i;
    // x0 is hard-wired, so a load targeting it can never create a hazard.
    load_use_o   = execute_valid_i && decode_valid_i && execute_mem_read_i &&
                   (execute_rd_i != '0) && (rs1_hit || rs2_hit);
    // A branch stuck behind a memory wait is not honoured until the wait ends.
    branch_o     = branch_valid_i && branch_taken_i && !mem_wait_o;
    fetch_wait_o = !fetch_ready_i;
  end

endmodule

// File: rtl/rv32_pipeline_ctrl.sv
// Pipeline control for the rv32 in-order core: stage valid tracking, prioritised
// stall/flush generation and saturating stall/redirect performance counters.
module rv32_pipeline_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = 5,
  parameter int unsigned MEM_STAGE     = 3,
  parameter int unsigned BRANCH_STAGE  = 3,
  parameter int unsigned REG_BITS      = 5,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fetch_ready_in,
  input  logic                     mem_access_in,
  input  logic                     mem_ready_in,
  input  logic                     branch_taken_in,
  input  logic [REG_BITS-1:0]      decode_rs1_in,
  input  logic [REG_BITS-1:0]      decode_rs2_in,
  input  logic                     decode_rs1_used_in,
  input  logic                     decode_rs2_used_in,
  input  logic [REG_BITS-1:0]      execute_rd_in,
  input  logic                     execute_mem_read_en_in,
  output logic [NUM_STAGES-1:0]    valid_out,
  output logic [NUM_STAGES-1:0]    stall_out,
  output logic [NUM_STAGES-1:0]    flush_out,
  output logic [COUNTER_WIDTH-1:0] stall_count_out,
  output logic [COUNTER_WIDTH-1:0] flush_count_out
);

  localparam logic [NUM_STAGES-1:0] MemStallMask     = NUM_STAGES'(prefix_mask(MEM_STAGE));
  localparam logic [NUM_STAGES-1:0] MemFlushMask     =
    NUM_STAGES'(prefix_mask(MEM_STAGE + 1) & ~prefix_mask(MEM_STAGE));
  localparam logic [NUM_STAGES-1:0] BranchFlushMask  =
    NUM_STAGES'(prefix_mask(BRANCH_STAGE) & ~prefix_mask(STAGE_FETCH));
  localparam logic [NUM_STAGES-1:0] LoadUseStallMask = NUM_STAGES'(prefix_mask(MEM_STAGE - 2));
  localparam logic [NUM_STAGES-1:0] LoadUseFlushMask =
    NUM_STAGES'(prefix_mask(MEM_STAGE - 1) & ~prefix_mask(MEM_STAGE - 2));
  localparam logic [NUM_STAGES-1:0] FetchStallMask   = NUM_STAGES'(prefix_mask(STAGE_FETCH));
  localparam logic [NUM_STAGES-1:0] FetchFlushMask   =
    NUM_STAGES'(prefix_mask(STAGE_DECODE) & ~prefix_mask(STAGE_FETCH));

  logic [NUM_STAGES-1:0]    valid_q, valid_d;
  logic [NUM_STAGES-1:0]    stall, flush;
  logic [COUNTER_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [COUNTER_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                     mem_wait, branch, load_use, fetch_wait;
  ctrl_event_e              event_sel;

  rv32_hazard_detect #(
    .REG_BITS (REG_BITS)
  ) u_hazard_detect (
    .decode_valid_i     (valid_q[STAGE_DECODE]),
    .execute_valid_i    (valid_q[MEM_STAGE-1]),
    .mem_valid_i        (valid_q[MEM_STAGE]),
    .branch_valid_i     (valid_q[BRANCH_STAGE]),
    .fetch_ready_i      (fetch_ready_in),
    .mem_access_i       (mem_access_in),
    .mem_ready_i        (mem_ready_in),
    .branch_taken_i     (branch_taken_in),
    .rs1_i              (decode_rs1_in),
    .rs2_i              (decode_rs2_in),
    .rs1_used_i         (decode_rs1_used_in),
    .rs2_used_i         (decode_rs2_used_in),
    .execute_rd_i       (execute_rd_in),
    .execute_mem_read_i (execute_mem_read_en_in),
    .mem_wait_o         (mem_wait),
    .branch_o           (branch),
    .load_use_o         (load_use),
    .fetch_wait_o       (fetch_wait)
  );

  // Each higher event covers every stage a lower one touches, so one winner suffices.
  always_comb begin
    event_sel = EvNone;
    if (mem_wait)        event_sel = EvMemWait;
    else if (branch)     event_sel = EvBranch;
    else if (load_use)   event_sel = EvLoadUse;
    else if (fetch_wait) event_sel = EvFetchWait;
  end

  always_comb begin
    stall = '0;
    flush = '0;
    unique case (event_sel)
      EvMemWait: begin
        stall = MemStallMask;
        flush = MemFlushMask;
      end
      EvBranch: begin
        flush = BranchFlushMask;
      end
      EvLoadUse: begin
        stall = LoadUseStallMask;
        flush = LoadUseFlushMask;
      end
      EvFetchWait: begin
        stall = FetchStallMask;
        flush = FetchFlushMask;
      end
      EvNone: ;
      default: ;
    endcase
    if (!reset_n) begin
      stall = '0;
      flush = '0;
    end
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = 1'b1;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      valid_d[i] = stall[i] ? valid_q[i] : (flush[i] ? 1'b0 : valid_q[i-1]);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (|stall) stall_cnt_d = COUNTER_WIDTH'(sat_inc(32'(stall_cnt_q), COUNTER_WIDTH));
    if (event_sel == EvBranch) begin
      flush_cnt_d = COUNTER_WIDTH'(sat_inc(32'(flush_cnt_q), COUNTER_WIDTH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign valid_out       = valid_q;
  assign stall_out       = stall;
  assign flush_out       = flush;
  assign stall_count_out = stall_cnt_q;
  assign flush_count_out = flush_cnt_q;

endmodule
